// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and note code constants for the note sequencer
package music_pkg;

    localparam int NOTE_W  = 4;
    localparam int OCT_W   = 2;
    localparam int ENTRY_W = NOTE_W + OCT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_GAP
    } seq_state_e;

    localparam logic [NOTE_W-1:0] NOTE_C  = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_CS = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_DS = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_E  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_F  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_FS = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_G  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_GS = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_A  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_AS = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_B  = 4'd11;

    // Buffer entries keep the octave in the upper bits.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [OCT_W-1:0]  oct,
                                                      input logic [NOTE_W-1:0] note);
        return {oct, note};
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - record/playback control and note output bundle
interface note_sequencer_if
    import music_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              rec_valid;
    logic [NOTE_W-1:0] rec_note;
    logic [OCT_W-1:0]  rec_octave;
    logic              play;
    logic              stop;
    logic              clear;
    logic [NOTE_W-1:0] note_out;
    logic [OCT_W-1:0]  octave_out;
    logic              ld_note;
    logic              note_valid;
    logic [CW-1:0]     count;
    logic              busy;
    logic              full;

    modport master (
        output rec_valid, rec_note, rec_octave, play, stop, clear,
        input  note_out, octave_out, ld_note, note_valid, count, busy, full
    );

    modport slave (
        input  rec_valid, rec_note, rec_octave, play, stop, clear,
        output note_out, octave_out, ld_note, note_valid, count, busy, full
    );

endinterface

// File: rtl/note_timer.sv
// rtl/note_timer.sv - loadable down-counter whose done flag marks zero
module note_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - note record buffer and timed playback; NOTE_SEQUENCER_LOOP_EN repeats playback
module note_sequencer
    import music_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    note_sequencer_if.slave bus
);

    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    // LOAD is the first sounding cycle, so HOLD covers the remaining NOTE_CYCLES-1.
    localparam logic [TW-1:0] HOLD_LOAD = TW'((NOTE_CYCLES > 1) ? NOTE_CYCLES - 2 : 0);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
`ifdef NOTE_SEQUENCER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    seq_state_e         state_q;
    logic [CW-1:0]      count_q;
    logic [IW-1:0]      index_q;
    logic [IW-1:0]      index_d;
    logic [NOTE_W-1:0]  note_q;
    logic [OCT_W-1:0]   oct_q;
    logic               ld_q;
    logic               valid_q;
    logic               busy_q;
    logic [ENTRY_W-1:0] buf_q [DEPTH];
    logic [ENTRY_W-1:0] rd_entry;
    logic               full;
    logic               wr_en;
    logic               last_entry;
    logic               tmr_load;
    logic               tmr_done;
    logic [TW-1:0]      tmr_val;

    assign full       = (count_q == CW'(DEPTH));
    assign wr_en      = (state_q == S_IDLE) && bus.rec_valid && !bus.clear && !full;
    assign last_entry = (CW'(index_q) + CW'(1)) >= count_q;

    // Buffer contents survive reset and clear; only count_q defines what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            buf_q[count_q[IW-1:0]] <= pack_entry(bus.rec_octave, bus.rec_note);
        end
    end

    always_comb begin
        index_d = '0;
        if ((state_q == S_GAP) && !last_entry) begin
            index_d = index_q + IW'(1);
        end
    end

    assign rd_entry = buf_q[index_d];

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;
        if (state_q == S_LOAD) begin
            tmr_load = 1'b1;
            tmr_val  = (NOTE_CYCLES > 1) ? HOLD_LOAD : GAP_LOAD;
        end else if ((state_q == S_HOLD) && tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
        end
    end

    note_timer #(
        .W(TW)
    ) u_timer (
        .clk_i      (CLOCK_50),
        .rst_ni     (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            index_q <= '0;
            note_q  <= '0;
            oct_q   <= '0;
            ld_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ld_q <= 1'b0;
            if ((state_q != S_IDLE) && bus.stop) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.clear) begin
                            count_q <= '0;
                        end else if (bus.rec_valid) begin
                            if (!full) count_q <= count_q + CW'(1);
                        end else if (bus.play && (count_q != '0)) begin
                            state_q           <= S_LOAD;
                            index_q           <= index_d;
                            {oct_q, note_q}   <= rd_entry;
                            ld_q              <= 1'b1;
                            valid_q           <= 1'b1;
                            busy_q            <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (NOTE_CYCLES > 1) begin
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_GAP;
                            valid_q <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (tmr_done) begin
                            state_q <= S_GAP;
                            valid_q <= 1'b0;
                        end
                    end
                    S_GAP: begin
                        if (tmr_done) begin
                            if (!last_entry || LOOP_EN) begin
                                state_q         <= S_LOAD;
                                index_q         <= index_d;
                                {oct_q, note_q} <= rd_entry;
                                ld_q            <= 1'b1;
                                valid_q         <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.note_out   = note_q;
    assign bus.octave_out = oct_q;
    assign bus.ld_note    = ld_q;
    assign bus.note_valid = valid_q;
    assign bus.count      = count_q;
    assign bus.busy       = busy_q;
    assign bus.full       = full;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;
    import music_pkg::*;

    localparam int DEPTH       = 4;
    localparam int NOTE_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int PERIOD      = NOTE_CYCLES + GAP_CYCLES;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    note_sequencer_if #(.DEPTH(DEPTH)) bus ();

    note_sequencer #(
        .DEPTH       (DEPTH),
        .NOTE_CYCLES (NOTE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.rec_valid  = 1'b0;
        bus.rec_note   = '0;
        bus.rec_octave = '0;
        bus.play       = 1'b0;
        bus.stop       = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic record(input logic [NOTE_W-1:0] n, input logic [OCT_W-1:0] o);
        bus.rec_note   = n;
        bus.rec_octave = o;
        bus.rec_valid  = 1'b1;
        cyc(1);
        bus.rec_valid  = 1'b0;
    endtask

    task automatic pulse_play;
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ld_note, bus.note_valid, bus.busy, bus.full} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.ld_note, bus.note_valid, bus.busy, bus.full});
        end
        checks++;
        if ({bus.octave_out, bus.note_out} !== 6'd0) begin
            errors++;
            $display("FAIL reset_note: got %0h expected 0", {bus.octave_out, bus.note_out});
        end
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        checks++;
        if ({bus.busy, bus.count} !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0000", {bus.busy, bus.count});
        end
    endtask

    task automatic test_basic;
        logic [NOTE_W-1:0] en [3];
        logic [OCT_W-1:0]  eo [3];
        logic [8:0]        exp_v;
        logic [8:0]        got_v;
        logic              ld_e, val_e, busy_e;
        int                k;
        en = '{NOTE_C, NOTE_E, NOTE_G};
        eo = '{2'd1, 2'd2, 2'd1};
        do_reset();
        record(NOTE_C, 2'd1);
        record(NOTE_E, 2'd2);
        record(NOTE_G, 2'd1);
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 3", bus.count);
        end
        pulse_play();
        for (int t = 0; t <= 3 * PERIOD; t++) begin
            k      = (t < 3 * PERIOD) ? t / PERIOD : 2;
            ld_e   = (t % PERIOD == 0) && (t < 3 * PERIOD);
            val_e  = (t % PERIOD < NOTE_CYCLES) && (t < 3 * PERIOD);
            busy_e = (t < 3 * PERIOD);
            exp_v  = {ld_e, val_e, busy_e, eo[k], en[k]};
            got_v  = {bus.ld_note, bus.note_valid, bus.busy, bus.octave_out, bus.note_out};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL basic_t%0d: got %b expected %b", t, got_v, exp_v);
            end
            if (t < 3 * PERIOD) cyc(1);
        end
    endtask

    task automatic test_full;
        logic [NOTE_W-1:0] exp_n [4];
        logic [NOTE_W-1:0] got_n [4];
        int                pulses;
        exp_n = '{NOTE_D, NOTE_F, NOTE_A, NOTE_B};
        got_n = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_reset();
        for (int i = 0; i < 4; i++) record(exp_n[i], 2'(i));
        checks++;
        if ({bus.full, bus.count} !== 4'b1_100) begin
            errors++;
            $display("FAIL full_at_depth: got %b expected 1100", {bus.full, bus.count});
        end
        record(NOTE_DS, 2'd3);
        checks++;
        if ({bus.full, bus.count} !== 4'b1_100) begin
            errors++;
            $display("FAIL full_drop: got %b expected 1100", {bus.full, bus.count});
        end
        pulse_play();
        pulses = 0;
        for (int t = 0; t < 5 * PERIOD; t++) begin
            if (bus.ld_note === 1'b1) begin
                if (pulses < 4) got_n[pulses] = bus.note_out;
                pulses++;
            end
            cyc(1);
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL full_pulses: got %0d expected 4", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_n[i] !== exp_n[i]) begin
                errors++;
                $display("FAIL full_note%0d: got %0d expected %0d", i, got_n[i], exp_n[i]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_end: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_empty_play;
        logic seen;
        do_reset();
        pulse_play();
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            seen = seen | bus.ld_note | bus.busy | bus.note_valid;
            cyc(1);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL empty_play: got activity %b expected 0", seen);
        end
    endtask

    task automatic test_stop;
        do_reset();
        record(NOTE_CS, 2'd0);
        record(NOTE_FS, 2'd2);
        record(NOTE_AS, 2'd1);
        pulse_play();
        cyc(8);
        checks++;
        if ({bus.note_valid, bus.busy, bus.note_out} !== {2'b11, NOTE_FS}) begin
            errors++;
            $display("FAIL stop_second_hold: got %b expected %b", {bus.note_valid, bus.busy, bus.note_out}, {2'b11, NOTE_FS});
        end
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        checks++;
        if ({bus.note_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL stop_edge: got %b expected 00", {bus.note_valid, bus.busy});
        end
        cyc(3);
        checks++;
        if ({bus.busy, bus.ld_note, bus.note_out, bus.count} !== {2'b00, NOTE_FS, 3'd3}) begin
            errors++;
            $display("FAIL stop_hold_idle: got %b expected %b", {bus.busy, bus.ld_note, bus.note_out, bus.count}, {2'b00, NOTE_FS, 3'd3});
        end
        pulse_play();
        checks++;
        if ({bus.ld_note, bus.busy, bus.octave_out, bus.note_out} !== {2'b11, 2'd0, NOTE_CS}) begin
            errors++;
            $display("FAIL stop_replay: got %b expected %b", {bus.ld_note, bus.busy, bus.octave_out, bus.note_out}, {2'b11, 2'd0, NOTE_CS});
        end
        cyc(3 * PERIOD);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_replay_end: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_priority;
        do_reset();
        record(NOTE_D, 2'd0);
        bus.rec_note   = NOTE_A;
        bus.rec_octave = 2'd3;
        bus.rec_valid  = 1'b1;
        bus.play       = 1'b1;
        cyc(1);
        idle_inputs();
        checks++;
        if ({bus.count, bus.busy, bus.ld_note} !== {3'd2, 2'b00}) begin
            errors++;
            $display("FAIL prio_rec_play: got %b expected %b", {bus.count, bus.busy, bus.ld_note}, {3'd2, 2'b00});
        end
        cyc(2);
        pulse_play();
        cyc(2);
        bus.clear     = 1'b1;
        bus.rec_valid = 1'b1;
        cyc(1);
        idle_inputs();
        checks++;
        if ({bus.count, bus.busy} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL prio_clear_busy: got %b expected %b", {bus.count, bus.busy}, {3'd2, 1'b1});
        end
        cyc(3);
        checks++;
        if ({bus.ld_note, bus.octave_out, bus.note_out} !== {1'b1, 2'd3, NOTE_A}) begin
            errors++;
            $display("FAIL prio_second_note: got %b expected %b", {bus.ld_note, bus.octave_out, bus.note_out}, {1'b1, 2'd3, NOTE_A});
        end
        cyc(PERIOD);
        checks++;
        if ({bus.busy, bus.count} !== {1'b0, 3'd2}) begin
            errors++;
            $display("FAIL prio_end: got %b expected %b", {bus.busy, bus.count}, {1'b0, 3'd2});
        end
        bus.clear     = 1'b1;
        bus.rec_valid = 1'b1;
        bus.play      = 1'b1;
        cyc(1);
        idle_inputs();
        checks++;
        if ({bus.count, bus.busy} !== 4'd0) begin
            errors++;
            $display("FAIL prio_clear_wins: got %b expected 0000", {bus.count, bus.busy});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        record(NOTE_E, 2'd1);
        record(NOTE_GS, 2'd2);
        pulse_play();
        cyc(2);
        checks++;
        if (bus.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected 1", bus.note_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.note_out, bus.octave_out, bus.ld_note, bus.note_valid, bus.busy, bus.full, bus.count} !== 13'd0) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 0", {bus.note_out, bus.octave_out, bus.ld_note, bus.note_valid, bus.busy, bus.full, bus.count});
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pulse_play();
        cyc(2);
        checks++;
        if ({bus.busy, bus.note_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_lost: got %b expected 00", {bus.busy, bus.note_valid});
        end
    endtask

    task automatic test_loop;
        logic [NOTE_W-1:0] got_n [4];
        int                pulses;
        got_n = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_reset();
        record(NOTE_F, 2'd1);
        record(NOTE_B, 2'd2);
        pulse_play();
        pulses = 0;
`ifdef NOTE_SEQUENCER_LOOP_EN
        for (int t = 0; t < 4 * PERIOD; t++) begin
            if (bus.ld_note === 1'b1) begin
                if (pulses < 4) got_n[pulses] = bus.note_out;
                pulses++;
            end
            cyc(1);
        end
        checks++;
        if ({pulses == 4, got_n[0], got_n[1], got_n[2], got_n[3]} !== {1'b1, NOTE_F, NOTE_B, NOTE_F, NOTE_B}) begin
            errors++;
            $display("FAIL loop_seq: got %0d pulses %0d,%0d,%0d,%0d expected 4 pulses 5,11,5,11", pulses, got_n[0], got_n[1], got_n[2], got_n[3]);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_busy: got %b expected 1", bus.busy);
        end
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        checks++;
        if ({bus.busy, bus.note_valid} !== 2'b00) begin
            errors++;
            $display("FAIL loop_stop: got %b expected 00", {bus.busy, bus.note_valid});
        end
`else
        for (int t = 0; t < 3 * PERIOD; t++) begin
            if (bus.ld_note === 1'b1) begin
                if (pulses < 4) got_n[pulses] = bus.note_out;
                pulses++;
            end
            cyc(1);
        end
        checks++;
        if ({pulses == 2, got_n[0], got_n[1]} !== {1'b1, NOTE_F, NOTE_B}) begin
            errors++;
            $display("FAIL once_seq: got %0d pulses %0d,%0d expected 2 pulses 5,11", pulses, got_n[0], got_n[1]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL once_end: got %b expected 0", bus.busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_empty_play();
        test_stop();
        test_priority();
        test_reset_mid();
        test_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
